// File: rtl/battleship_pkg.sv
// Shared fleet geometry, board cell layout and resolver state encoding for the battleship game blocks.
package battleship_pkg;

  localparam int BOARD_DIM   = 10;
  localparam int SHIP_COUNT  = 5;
  localparam int TOTAL_CELLS = 17;

  // Packed per-ship lengths, ship id 1 in the least significant 3 bits
  localparam logic [3*SHIP_COUNT-1:0] SHIP_LEN = {3'd2, 3'd3, 3'd3, 3'd4, 3'd5};

  localparam int CELL_W   = 10;
  localparam int ID_LSB   = 0;
  localparam int ID_MSB   = 3;
  localparam int HIT_BIT  = 4;
  localparam int SHOT_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_ship(input logic [3:0] id);
    return (id != 4'd0) && (int'(id) <= SHIP_COUNT);
  endfunction

  function automatic logic [2:0] ship_len(input logic [3:0] id);
    logic [2:0] len;
    len = 3'd0;
    for (int i = 1; i <= SHIP_COUNT; i++) begin
      if (int'(id) == i) len = SHIP_LEN[(i-1)*3 +: 3];
    end
    return len;
  endfunction

endpackage

// File: rtl/ship_tracker.sv
// Per-ship damage counters with sunk detection, remaining undamaged cell count and sticky game over.
module ship_tracker
  import battleship_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       soft_rst_i,
  input  logic       hit_i,
  input  logic [3:0] ship_id_i,
  output logic       sunk_o,
  output logic [4:0] hits_remaining_o,
  output logic       game_over_o
);

  logic [2:0] cnt_q [SHIP_COUNT];
  logic [4:0] rem_q;
  logic       go_q;
  logic [2:0] cur;
  logic [2:0] len;
  logic       bump;

  // Saturating counters keep a corrupt board (extra cells for one id) from wrapping
  always_comb begin
    cur = 3'd0;
    for (int i = 0; i < SHIP_COUNT; i++) begin
      if (int'(ship_id_i) == i + 1) cur = cnt_q[i];
    end
    len    = ship_len(ship_id_i);
    bump   = hit_i && is_ship(ship_id_i) && (cur < len);
    sunk_o = bump && ((cur + 3'd1) == len);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SHIP_COUNT; i++) cnt_q[i] <= 3'd0;
      rem_q <= 5'(TOTAL_CELLS);
      go_q  <= 1'b0;
    end else if (soft_rst_i) begin
      for (int i = 0; i < SHIP_COUNT; i++) cnt_q[i] <= 3'd0;
      rem_q <= 5'(TOTAL_CELLS);
      go_q  <= 1'b0;
    end else if (bump) begin
      for (int i = 0; i < SHIP_COUNT; i++) begin
        if (int'(ship_id_i) == i + 1) cnt_q[i] <= cur + 3'd1;
      end
      if (rem_q != 5'd0) rem_q <= rem_q - 5'd1;
      if (rem_q == 5'd1) go_q <= 1'b1;
    end
  end

  assign hits_remaining_o = rem_q;
  assign game_over_o      = go_q;

endmodule

// File: rtl/shot_resolver.sv
// Resolves opponent shots against the local board: read cell, classify, write back, report result.
// Sole writer of the local board during play; fleet damage is kept in ship_tracker.
module shot_resolver
  import battleship_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SoftReset,
  input  logic              ShotValid,
  output logic              ShotReady,
  input  logic [3:0]        ShotRow,
  input  logic [3:0]        ShotCol,
  output logic [3:0]        RMyPosRow,
  output logic [3:0]        RMyPosCol,
  input  logic [CELL_W-1:0] RMyPosData,
  output logic              WMyPosEnable,
  output logic [3:0]        WMyPosRow,
  output logic [3:0]        WMyPosCol,
  output logic [CELL_W-1:0] WMyPosData,
  output logic              ResultValid,
  output logic              ResultHit,
  output logic              ResultSunk,
  output logic              ResultRepeat,
  output logic              ResultInvalid,
  output logic [3:0]        ResultShipId,
  output logic [4:0]        HitsRemaining,
  output logic              GameOver
);

  state_e     state_q, state_d;
  logic [3:0] row_q, row_d, col_q, col_d;
  logic       valid_q, valid_d, hit_q, hit_d, sunk_q, sunk_d;
  logic       rep_q, rep_d, inv_q, inv_d;
  logic [3:0] id_q, id_d;

  logic [3:0] cell_id;
  logic       cell_shot, cell_ship;
  logic       trk_hit, trk_sunk, game_over;
  logic [4:0] hits_rem;

  assign cell_id   = RMyPosData[ID_MSB:ID_LSB];
  assign cell_shot = RMyPosData[SHOT_BIT];
  assign cell_ship = is_ship(cell_id);
  assign trk_hit   = (state_q == ST_EVAL) && !cell_shot && cell_ship && !SoftReset;

  ship_tracker u_tracker (
    .clk_i            (Clock),
    .rst_i            (Reset),
    .soft_rst_i       (SoftReset),
    .hit_i            (trk_hit),
    .ship_id_i        (cell_id),
    .sunk_o           (trk_sunk),
    .hits_remaining_o (hits_rem),
    .game_over_o      (game_over)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      sunk_q  <= 1'b0;
      rep_q   <= 1'b0;
      inv_q   <= 1'b0;
      id_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      sunk_q  <= sunk_d;
      rep_q   <= rep_d;
      inv_q   <= inv_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    valid_d      = 1'b0;
    hit_d        = 1'b0;
    sunk_d       = 1'b0;
    rep_d        = 1'b0;
    inv_d        = 1'b0;
    id_d         = 4'd0;
    ShotReady    = (state_q == ST_IDLE) && !game_over;
    WMyPosEnable = 1'b0;
    WMyPosData   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (ShotValid && ShotReady) begin
          row_d = ShotRow;
          col_d = ShotCol;
          if ((ShotRow >= 4'(BOARD_DIM)) || (ShotCol >= 4'(BOARD_DIM))) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            inv_d   = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_EVAL;
      ST_EVAL: begin
        state_d = ST_DONE;
        valid_d = 1'b1;
        if (cell_shot) begin
          rep_d = 1'b1;
        end else begin
          WMyPosEnable         = 1'b1;
          WMyPosData           = RMyPosData;
          WMyPosData[SHOT_BIT] = 1'b1;
          if (cell_ship) begin
            WMyPosData[HIT_BIT] = 1'b1;
            hit_d  = 1'b1;
            id_d   = cell_id;
            sunk_d = trk_sunk;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // New-game clear takes priority: drop any write or result that was about to happen
    if (SoftReset) begin
      state_d      = ST_IDLE;
      row_d        = 4'd0;
      col_d        = 4'd0;
      valid_d      = 1'b0;
      hit_d        = 1'b0;
      sunk_d       = 1'b0;
      rep_d        = 1'b0;
      inv_d        = 1'b0;
      id_d         = 4'd0;
      WMyPosEnable = 1'b0;
      WMyPosData   = '0;
    end
  end

  assign RMyPosRow     = row_q;
  assign RMyPosCol     = col_q;
  assign WMyPosRow     = row_q;
  assign WMyPosCol     = col_q;
  assign ResultValid   = valid_q;
  assign ResultHit     = hit_q;
  assign ResultSunk    = sunk_q;
  assign ResultRepeat  = rep_q;
  assign ResultInvalid = inv_q;
  assign ResultShipId  = id_q;
  assign HitsRemaining = hits_rem;
  assign GameOver      = game_over;

endmodule

// File: tb/tb_shot_resolver.sv
// Directed bench for shot_resolver: a full game from a table of shots plus abort and game-over sequences.
module tb_shot_resolver;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       SoftReset = 1'b0;
  logic       ShotValid = 1'b0;
  logic       ShotReady;
  logic [3:0] ShotRow = 4'd0;
  logic [3:0] ShotCol = 4'd0;
  logic [3:0] RMyPosRow, RMyPosCol;
  logic [9:0] RMyPosData = 10'h000;
  logic       WMyPosEnable;
  logic [3:0] WMyPosRow, WMyPosCol;
  logic [9:0] WMyPosData;
  logic       ResultValid, ResultHit, ResultSunk, ResultRepeat, ResultInvalid;
  logic [3:0] ResultShipId;
  logic [4:0] HitsRemaining;
  logic       GameOver;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  shot_resolver dut (
    .Clock(Clock), .Reset(Reset), .SoftReset(SoftReset),
    .ShotValid(ShotValid), .ShotReady(ShotReady), .ShotRow(ShotRow), .ShotCol(ShotCol),
    .RMyPosRow(RMyPosRow), .RMyPosCol(RMyPosCol), .RMyPosData(RMyPosData),
    .WMyPosEnable(WMyPosEnable), .WMyPosRow(WMyPosRow), .WMyPosCol(WMyPosCol),
    .WMyPosData(WMyPosData), .ResultValid(ResultValid), .ResultHit(ResultHit),
    .ResultSunk(ResultSunk), .ResultRepeat(ResultRepeat), .ResultInvalid(ResultInvalid),
    .ResultShipId(ResultShipId), .HitsRemaining(HitsRemaining), .GameOver(GameOver)
  );

  // Board RAM model: registered read, write on strobe
  logic [9:0] mem [16][16];
  int         wr_cnt = 0;
  logic [3:0] wr_row = 4'd0, wr_col = 4'd0;
  logic [9:0] wr_data = 10'h000;

  always @(posedge Clock) begin
    RMyPosData <= mem[RMyPosRow][RMyPosCol];
    if (WMyPosEnable) begin
      mem[WMyPosRow][WMyPosCol] = WMyPosData;
      wr_cnt++;
      wr_row  = WMyPosRow;
      wr_col  = WMyPosCol;
      wr_data = WMyPosData;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_board();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mem[r][c] = 10'h000;
    for (int c = 0; c < 5; c++) mem[1][c] = 10'h001;
    for (int c = 0; c < 4; c++) mem[3][c] = 10'h002;
    mem[3][3] = 10'h3C2;
    for (int c = 0; c < 3; c++) begin
      mem[5][c] = 10'h003;
      mem[7][c] = 10'h004;
    end
    mem[0][0] = 10'h005;
    mem[0][1] = 10'h005;
    mem[9][9] = 10'h00C;
  endtask

  typedef struct {
    logic [3:0] r, c;
    logic       hit, sunk, rep, inv;
    logic [3:0] id;
    logic [9:0] wdata;
    logic [4:0] rem;
    logic       go;
  } vec_t;

  vec_t vecs [$];

  task automatic add(input logic [3:0] r, c, input logic hit, sunk, rep, inv,
                     input logic [3:0] id, input logic [9:0] wd, input logic [4:0] rem,
                     input logic go);
    vec_t v;
    v.r = r; v.c = c; v.hit = hit; v.sunk = sunk; v.rep = rep; v.inv = inv;
    v.id = id; v.wdata = wd; v.rem = rem; v.go = go;
    vecs.push_back(v);
  endtask

  int         lat;
  logic       s_hit, s_sunk, s_rep, s_inv, s_go;
  logic [3:0] s_id;
  logic [4:0] s_rem;

  // Fire one shot; lat = sample index (negedges after accept) of the result pulse, 0 on timeout
  task automatic fire(input logic [3:0] r, input logic [3:0] c);
    int n;
    @(negedge Clock);
    ShotValid = 1'b1; ShotRow = r; ShotCol = c;
    @(negedge Clock);
    ShotValid = 1'b0; ShotRow = r ^ 4'hF; ShotCol = ~c;
    n = 1;
    while (!ResultValid && n < 8) begin
      @(negedge Clock);
      n++;
    end
    lat   = ResultValid ? n : 0;
    s_hit = ResultHit; s_sunk = ResultSunk; s_rep = ResultRepeat; s_inv = ResultInvalid;
    s_id  = ResultShipId; s_rem = HitsRemaining; s_go = GameOver;
  endtask

  task automatic abort_eval(input logic [3:0] r, c, input logic hard, input string tag);
    int wb, rv;
    wb = wr_cnt;
    rv = 0;
    @(negedge Clock);
    ShotValid = 1'b1; ShotRow = r; ShotCol = c;
    @(negedge Clock);
    ShotValid = 1'b0;
    @(negedge Clock);
    chk({tag, "_eval_wen"}, int'(WMyPosEnable), 1);
    if (hard) Reset = 1'b1;
    else SoftReset = 1'b1;
    #1;
    chk({tag, "_wen_drop"}, int'(WMyPosEnable), 0);
    @(negedge Clock);
    Reset = 1'b0; SoftReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ResultValid) rv++;
      @(negedge Clock);
    end
    chk({tag, "_no_result"}, rv, 0);
    chk({tag, "_no_write"}, wr_cnt - wb, 0);
    chk({tag, "_ready"}, int'(ShotReady), 1);
    chk({tag, "_rem"}, int'(HitsRemaining), 17);
    chk({tag, "_go"}, int'(GameOver), 0);
    chk({tag, "_raddr"}, int'({RMyPosRow, RMyPosCol}), 0);
    chk({tag, "_waddr"}, int'({WMyPosRow, WMyPosCol}), 0);
    chk({tag, "_wdata"}, int'(WMyPosData), 0);
    chk({tag, "_flags"}, int'({ResultHit, ResultSunk, ResultRepeat, ResultInvalid, ResultShipId}), 0);
    chk({tag, "_cell"}, int'(mem[r][c]), int'(r == 4'd0 ? 10'h005 : 10'h001));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rv;
    load_board();

    //   r  c  hit sunk rep inv id  wdata    rem  go
    add(2, 3, 0, 0, 0, 0, 0, 10'h020, 17, 0);
    add(0, 0, 1, 0, 0, 0, 5, 10'h035, 16, 0);
    add(0, 0, 0, 0, 1, 0, 0, 10'h000, 16, 0);
    add(10, 4, 0, 0, 0, 1, 0, 10'h000, 16, 0);
    add(3, 15, 0, 0, 0, 1, 0, 10'h000, 16, 0);
    add(9, 9, 0, 0, 0, 0, 0, 10'h02C, 16, 0);
    add(3, 3, 1, 0, 0, 0, 2, 10'h3F2, 15, 0);
    add(0, 1, 1, 1, 0, 0, 5, 10'h035, 14, 0);
    add(1, 0, 1, 0, 0, 0, 1, 10'h031, 13, 0);
    add(1, 1, 1, 0, 0, 0, 1, 10'h031, 12, 0);
    add(1, 2, 1, 0, 0, 0, 1, 10'h031, 11, 0);
    add(1, 3, 1, 0, 0, 0, 1, 10'h031, 10, 0);
    add(1, 4, 1, 1, 0, 0, 1, 10'h031, 9, 0);
    add(3, 0, 1, 0, 0, 0, 2, 10'h032, 8, 0);
    add(3, 1, 1, 0, 0, 0, 2, 10'h032, 7, 0);
    add(3, 2, 1, 1, 0, 0, 2, 10'h032, 6, 0);
    add(5, 0, 1, 0, 0, 0, 3, 10'h033, 5, 0);
    add(5, 1, 1, 0, 0, 0, 3, 10'h033, 4, 0);
    add(5, 2, 1, 1, 0, 0, 3, 10'h033, 3, 0);
    add(7, 0, 1, 0, 0, 0, 4, 10'h034, 2, 0);
    add(7, 1, 1, 0, 0, 0, 4, 10'h034, 1, 0);
    add(7, 2, 1, 1, 0, 0, 4, 10'h034, 0, 1);

    repeat (3) @(negedge Clock);
    chk("rst_ready_in_reset", int'(ShotReady), 1);
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_ready", int'(ShotReady), 1);
    chk("rst_valid", int'(ResultValid), 0);
    chk("rst_wen", int'(WMyPosEnable), 0);
    chk("rst_rem", int'(HitsRemaining), 17);
    chk("rst_go", int'(GameOver), 0);
    chk("rst_addr", int'({RMyPosRow, RMyPosCol, WMyPosRow, WMyPosCol}), 0);
    chk("rst_wdata", int'(WMyPosData), 0);
    chk("rst_flags", int'({ResultHit, ResultSunk, ResultRepeat, ResultInvalid, ResultShipId}), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      int   ew;
      v  = vecs[i];
      ew = (v.inv || v.rep) ? 0 : 1;
      wb = wr_cnt;
      fire(v.r, v.c);
      chk($sformatf("v%0d_latency", i), lat, v.inv ? 1 : 3);
      chk($sformatf("v%0d_hit", i), int'(s_hit), int'(v.hit));
      chk($sformatf("v%0d_sunk", i), int'(s_sunk), int'(v.sunk));
      chk($sformatf("v%0d_repeat", i), int'(s_rep), int'(v.rep));
      chk($sformatf("v%0d_invalid", i), int'(s_inv), int'(v.inv));
      chk($sformatf("v%0d_shipid", i), int'(s_id), int'(v.id));
      chk($sformatf("v%0d_rem", i), int'(s_rem), int'(v.rem));
      chk($sformatf("v%0d_gameover", i), int'(s_go), int'(v.go));
      chk($sformatf("v%0d_nwrites", i), wr_cnt - wb, ew);
      if (ew == 1) begin
        chk($sformatf("v%0d_wdata", i), int'(wr_data), int'(v.wdata));
        chk($sformatf("v%0d_waddr", i), int'({wr_row, wr_col}), int'({v.r, v.c}));
      end
      @(negedge Clock);
      chk($sformatf("v%0d_pulse_end", i), int'(ResultValid), 0);
    end

    // Game over: further shots are ignored
    chk("go_ready", int'(ShotReady), 0);
    wb = wr_cnt;
    rv = 0;
    ShotValid = 1'b1; ShotRow = 4'd2; ShotCol = 4'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (ResultValid) rv++;
    end
    ShotValid = 1'b0;
    chk("go_ignored_result", rv, 0);
    chk("go_ignored_write", wr_cnt - wb, 0);
    chk("go_sticky", int'(GameOver), 1);

    // New game via SoftReset
    SoftReset = 1'b1;
    @(negedge Clock);
    SoftReset = 1'b0;
    chk("soft_rem", int'(HitsRemaining), 17);
    chk("soft_go", int'(GameOver), 0);
    chk("soft_ready", int'(ShotReady), 1);
    load_board();

    fire(0, 0);
    chk("soft_pre_hit", int'(s_hit), 1);
    chk("soft_pre_rem", int'(s_rem), 16);
    @(negedge Clock);
    abort_eval(0, 1, 1'b0, "soft_abort");

    load_board();
    fire(1, 0);
    chk("hard_pre_rem", int'(s_rem), 16);
    @(negedge Clock);
    abort_eval(1, 1, 1'b1, "hard_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_resolver.md
# shot_resolver

Resolves incoming opponent shots against the local fleet board held in the game-state RAMs. It sits directly upstream of the game-state block's `WMyPos*` write port and is the sole writer of the local board during play. For each shot it reads the target cell, classifies it as miss, hit, repeat or invalid, and writes the updated cell back. It also tracks per-ship damage, sunk events and game over.

## Interface
Parameters:
- `BOARD_DIM`, 10: valid row/col range is 0..BOARD_DIM-1.
- `SHIP_COUNT`, 5: ship ids are 1..SHIP_COUNT.
- `SHIP_LEN`, {5,4,3,3,2}: length of ship ids 1..5.
- `TOTAL_CELLS`, 17: sum of SHIP_LEN.

Ports:
- `Clock` in 1: system clock.
- `Reset` in 1: asynchronous, active-high.
- `SoftReset` in 1: synchronous new-game clear.
- `ShotValid` in 1: shot request.
- `ShotReady` out 1: block can accept a shot.
- `ShotRow` in 4: target row.
- `ShotCol` in 4: target column.
- `RMyPosRow` out 4: board read row address.
- `RMyPosCol` out 4: board read column address.
- `RMyPosData` in 10: board read data, registered, valid 1 cycle after address.
- `WMyPosEnable` out 1: board write strobe.
- `WMyPosRow` out 4: board write row address.
- `WMyPosCol` out 4: board write column address.
- `WMyPosData` out 10: board write data.
- `ResultValid` out 1: one-cycle result pulse.
- `ResultHit` out 1: result is a hit.
- `ResultSunk` out 1: result sank a ship.
- `ResultRepeat` out 1: target cell was already shot.
- `ResultInvalid` out 1: coordinates out of range.
- `ResultShipId` out 4: id of the ship hit, 0 otherwise.
- `HitsRemaining` out 5: undamaged ship cells left.
- `GameOver` out 1: all ships sunk.

## Operation
- Cell format:
  - [3:0] ship id (0 = water; ids > SHIP_COUNT are treated as water).
  - [4] hit.
  - [5] shot.
  - [9:6] reserved; written back unchanged.
- FSM states: IDLE, READ, EVAL, DONE.
- IDLE:
  - `ShotReady` = !GameOver.
  - On `ShotValid & ShotReady`, latch row/col.
  - If row or col ≥ BOARD_DIM, go to DONE with invalid result; otherwise go to READ.
- READ: drive `RMyPos*` with the latched address (held through EVAL); go to EVAL.
- EVAL: classify the returned cell.
  - Shot bit set: repeat. No write.
  - Water: miss. Write the cell with shot=1.
  - Valid id: hit. Write the cell with shot=1 and hit=1.
    - Increment that ship's hit counter and decrement HitsRemaining.
    - When the counter reaches SHIP_LEN[id], set Sunk.
    - When HitsRemaining reaches 0, set GameOver.
- The write is a single-cycle `WMyPosEnable` pulse in EVAL. Write address equals the latched address.
- DONE: assert `ResultValid` for exactly one cycle together with the registered Result* flags; return to IDLE.
- Result flags are mutually exclusive except `ResultSunk`, which is set only together with `ResultHit`. `ResultShipId` is 0 unless `ResultHit` is set.
- GameOver is sticky until Reset or SoftReset. While GameOver is set, `ShotReady` = 0.
- SoftReset behaves like Reset but is synchronous: FSM returns to IDLE, counters clear, and no pending write is issued. It does not clear the RAM; board reload is the placement logic's job.

## Timing
- Reset values:
  - `ShotReady` = 1.
  - All Result*, `WMyPosEnable` and `GameOver` = 0.
  - `HitsRemaining` = TOTAL_CELLS.
  - `RMyPos*` and `WMyPos*` addresses and data = 0.
- Valid shot:
  - Accepted at edge N.
  - READ during cycle N..N+1; RAM samples the address at N+1.
  - EVAL during N+1..N+2; write committed at edge N+2.
  - `ResultValid` high during cycle N+2..N+3.
- Invalid shot: `ResultValid` in the cycle immediately after acceptance.
- Back-to-back: a new shot is accepted no earlier than the cycle after DONE. Throughput is 1 shot per 4 cycles.
- `ShotRow`/`ShotCol` are sampled only at acceptance and may change afterward.
- Reset or SoftReset asserted in EVAL suppresses that cycle's write and any result pulse.
- `HitsRemaining` and `GameOver` update at the EVAL→DONE edge, so they are coherent with `ResultValid`.

## Structure
- Shared package `battleship_pkg` holds:
  - `BOARD_DIM`, `SHIP_COUNT`, `SHIP_LEN` and `TOTAL_CELLS`.
  - Cell field bit positions (ID_LSB/MSB, HIT_BIT, SHOT_BIT).
  - FSM state encoding.
- Sub-module `ship_tracker` holds the per-ship 3-bit hit counters, sunk detect, `HitsRemaining` and `GameOver`. Its inputs are a hit strobe plus ship id; its outputs are a sunk pulse, the remaining count and game over. It clears on Reset/SoftReset.

## Test plan
- Miss: cell (2,3) = 0x000, shot (2,3) → write 0x020 to (2,3); ResultValid 3 cycles after accept with all flags 0; HitsRemaining = 17.
- Hit then repeat: cell (0,0) = 0x005, shot (0,0) → write 0x035; ResultHit = 1, ResultShipId = 5, HitsRemaining = 16. Same shot again → ResultRepeat = 1, no write, count unchanged.
- Sink and game over: hit all 17 fleet cells → ResultSunk on the 5th hit of ship 1 and the 2nd hit of ship 5. GameOver rises with the final ResultValid, then ShotReady = 0 and further ShotValid is ignored.
- Invalid: shot (10,4) and shot (3,15) → ResultInvalid = 1 one cycle after accept, no read, no write.
- Reserved bits: cell 0x3C2 → write 0x3F2; ResultHit, ship 2.
- Abort: assert Reset during EVAL of a hit → no WMyPosEnable, no ResultValid, all outputs at reset values. Repeat the abort with SoftReset → same result, and GameOver and HitsRemaining cleared.
